// File: rtl/if_stage_ifid_reg_if.sv
// ---------------------------------------------------------------------------
// if_stage_ifid_reg_if
//
// Bundles every non-clock/non-reset signal of the instruction-fetch stage.
//
//   Control inputs to the fetch stage:
//     start_i          start request (sticky once seen)
//     PCWrite_i        PC write enable from the hazard detector (0 = hold PC)
//     stall_i          IF/ID hold request from the hazard detector
//     flush_i          branch taken in ID, discard the fetch in flight
//     branch_target_i  redirect address, meaningful while flush_i=1
//     instr_i          instruction memory read data for pc_o (same cycle)
//   Outputs of the fetch stage:
//     pc_o             current fetch address
//     IFID_pc_o        PC of the instruction held in IF/ID
//     IFID_instr_o     instruction held in IF/ID
//     IFID_valid_o     1 = real instruction, 0 = bubble
//     stall_cnt_o      saturating count of started stall cycles
//     flush_cnt_o      saturating count of accepted flushes
//
// Modports:
//   slave  - the fetch stage itself
//   master - whatever drives it (pipeline control / instruction memory / bench)
// ---------------------------------------------------------------------------
interface if_stage_ifid_reg_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 start_i;
    logic                 PCWrite_i;
    logic                 stall_i;
    logic                 flush_i;
    logic [31:0]          branch_target_i;
    logic [31:0]          instr_i;
    logic [31:0]          pc_o;
    logic [31:0]          IFID_pc_o;
    logic [31:0]          IFID_instr_o;
    logic                 IFID_valid_o;
    logic [CNT_WIDTH-1:0] stall_cnt_o;
    logic [CNT_WIDTH-1:0] flush_cnt_o;

    modport slave (
        input  start_i,
        input  PCWrite_i,
        input  stall_i,
        input  flush_i,
        input  branch_target_i,
        input  instr_i,
        output pc_o,
        output IFID_pc_o,
        output IFID_instr_o,
        output IFID_valid_o,
        output stall_cnt_o,
        output flush_cnt_o
    );

    modport master (
        output start_i,
        output PCWrite_i,
        output stall_i,
        output flush_i,
        output branch_target_i,
        output instr_i,
        input  pc_o,
        input  IFID_pc_o,
        input  IFID_instr_o,
        input  IFID_valid_o,
        input  stall_cnt_o,
        input  flush_cnt_o
    );
endinterface

// File: rtl/if_stage_ifid_reg.sv
// ---------------------------------------------------------------------------
// if_stage_ifid_reg
//
// Instruction-fetch front end: owns the program counter and the IF/ID latch.
// The PC drives instruction memory directly (pc_o is the PC register), and
// the memory answers combinationally on instr_i in the same cycle. Each
// running edge either advances the PC by 4, redirects it to a branch target,
// or holds it, and the IF/ID latch captures the fetched instruction, a
// bubble, or holds, according to the hazard detector and the ID-stage flush.
//
// Ports:
//   clk_i  clock, all state changes on the rising edge
//   rst_i  asynchronous active-low reset
//   bus    if_stage_ifid_reg_if.slave (control inputs, fetch/IFID outputs,
//          performance counters)
//
// Before the first start_i the stage idles: PC frozen at RESET_PC and the
// IF/ID latch is refilled with bubbles. The edge that samples start_i high is
// already a running edge.
// ---------------------------------------------------------------------------
module if_stage_ifid_reg #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    if_stage_ifid_reg_if.slave   bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      stateReg, stateNext;

    logic [31:0] pcReg, pcNext;
    logic [31:0] ifidPcReg, ifidPcNext;
    logic [31:0] ifidInstrReg, ifidInstrNext;
    logic        ifidValidReg, ifidValidNext;

    // True when this edge follows the running rules, including the edge
    // that first samples start_i.
    logic        runEdge;

    // Per-counter increment request: [0] = stall, [1] = flush.
    logic [1:0]  cntInc;
    logic [CNT_WIDTH-1:0] cntVal [2];

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stateReg     <= IDLE;
            pcReg        <= RESET_PC;
            ifidPcReg    <= 32'h0000_0000;
            ifidInstrReg <= NOP_INSTR;
            ifidValidReg <= 1'b0;
        end else begin
            stateReg     <= stateNext;
            pcReg        <= pcNext;
            ifidPcReg    <= ifidPcNext;
            ifidInstrReg <= ifidInstrNext;
            ifidValidReg <= ifidValidNext;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state / next-value logic
    // -----------------------------------------------------------------------
    always_comb begin
        stateNext     = stateReg;
        pcNext        = pcReg;
        ifidPcNext    = ifidPcReg;
        ifidInstrNext = ifidInstrReg;
        ifidValidNext = ifidValidReg;
        cntInc        = 2'b00;
        runEdge       = (stateReg == RUN) || bus.start_i;

        if (stateReg == IDLE && bus.start_i) begin
            stateNext = RUN;
        end

        if (!runEdge) begin
            // Idle: keep feeding bubbles tagged with the frozen PC.
            ifidPcNext    = pcReg;
            ifidInstrNext = NOP_INSTR;
            ifidValidNext = 1'b0;
        end else begin
            // PC: a stall always wins over a flush; the hazard detector
            // re-issues the flush once the stall has cleared.
            if (!bus.PCWrite_i || bus.stall_i) begin
                pcNext = pcReg;
            end else if (bus.flush_i) begin
                pcNext = {bus.branch_target_i[31:2], 2'b00};
            end else begin
                pcNext = pcReg + 32'd4;
            end

            // IF/ID: PCWrite_i alone does not hold the latch, so PCWrite_i=0
            // with no stall simply re-latches the same instruction.
            if (bus.stall_i) begin
                ifidPcNext    = ifidPcReg;
                ifidInstrNext = ifidInstrReg;
                ifidValidNext = ifidValidReg;
            end else if (bus.flush_i) begin
                ifidPcNext    = pcReg;
                ifidInstrNext = NOP_INSTR;
                ifidValidNext = 1'b0;
            end else begin
                ifidPcNext    = pcReg;
                ifidInstrNext = bus.instr_i;
                ifidValidNext = 1'b1;
            end

            cntInc[0] = bus.stall_i;
            cntInc[1] = bus.flush_i && !bus.stall_i;
        end
    end

    // -----------------------------------------------------------------------
    // Saturating performance counters
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gCnt
            logic [CNT_WIDTH-1:0] cntReg;

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    cntReg <= '0;
                end else if (cntInc[gi] && !(&cntReg)) begin
                    cntReg <= cntReg + CNT_WIDTH'(1);
                end
            end

            assign cntVal[gi] = cntReg;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Outputs: all straight from registers
    // -----------------------------------------------------------------------
    assign bus.pc_o         = pcReg;
    assign bus.IFID_pc_o    = ifidPcReg;
    assign bus.IFID_instr_o = ifidInstrReg;
    assign bus.IFID_valid_o = ifidValidReg;
    assign bus.stall_cnt_o  = cntVal[0];
    assign bus.flush_cnt_o  = cntVal[1];

endmodule

// File: doc/if_stage_ifid_reg.md
Name: if_stage_ifid_reg

Overview:
Instruction-fetch front end of the 5-stage pipeline, directly upstream of the load-use hazard detector. It owns the program counter and the IF/ID pipeline latch, and consumes the hazard detector's PC-write-enable and IF/ID stall signals plus the branch-flush request from ID. It supplies the fetch address to instruction memory and the latched (pc, instruction, valid) triple to ID. It also keeps saturating stall and flush counters for performance debug.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) written into IF/ID on flush, reset or pre-start.
CNT_WIDTH, 32, width of each performance counter.

Ports:
clk_i  input  1  clock; all state updates on rising edge.
rst_i  input  1  asynchronous, active-low reset.
start_i  input  1  start request; first sample high sets internal sticky started flag.
PCWrite_i  input  1  PC write enable from hazard detector; 0 = hold PC.
stall_i  input  1  IF/ID hold request from hazard detector.
flush_i  input  1  branch taken in ID; discard the instruction being fetched.
branch_target_i  input  32  redirect address, valid when flush_i=1.
instr_i  input  32  instruction memory read data for pc_o (combinational, same cycle).
pc_o  output  32  current fetch address to instruction memory.
IFID_pc_o  output  32  PC of the instruction held in IF/ID.
IFID_instr_o  output  32  instruction held in IF/ID.
IFID_valid_o  output  1  1 = IF/ID holds a real instruction; 0 = bubble.
stall_cnt_o  output  CNT_WIDTH  count of started cycles with stall_i=1.
flush_cnt_o  output  CNT_WIDTH  count of accepted flushes.

Behaviour:
- Reset (rst_i=0, asynchronous, effective mid-cycle):
  - pc_o=RESET_PC, IFID_pc_o=0, IFID_instr_o=NOP_INSTR, IFID_valid_o=0, both counters 0, started=0.
  - All outputs hold these values while rst_i=0.
- States are IDLE (started=0) and RUN (started=1).
  - IDLE->RUN on a rising edge with start_i=1. That edge is already a RUN edge: PC and IF/ID update per RUN rules.
  - No return to IDLE except by reset. start_i is ignored in RUN.
- IDLE edges: PC holds; IF/ID loads NOP_INSTR, valid=0, pc=pc_o; counters hold.
- RUN edges, PC update in priority order:
  1. PCWrite_i=0 or stall_i=1: hold.
  2. flush_i=1: pc <= {branch_target_i[31:2],2'b00}.
  3. Else: pc <= pc_o+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- RUN edges, IF/ID update in priority order:
  1. stall_i=1: hold all three fields. flush_i is ignored in this cycle; the hazard detector re-raises it once the stall clears.
  2. flush_i=1: instr <= NOP_INSTR, valid <= 0, pc <= pc_o.
  3. Else: instr <= instr_i, pc <= pc_o, valid <= 1.
- PCWrite_i=0 with stall_i=0 (not produced by the hazard detector): PC holds; IF/ID loads normally, so the same instruction is latched again.
- Latency: an instruction at address A appears on IFID_* one edge after pc_o=A, provided that edge is not a stall.
- Counters (RUN only):
  - stall_cnt increments on each edge with stall_i=1.
  - flush_cnt increments on each edge with flush_i=1 and stall_i=0.
  - Both saturate at all-ones and never wrap.
- No combinational path from any input to any output. All outputs are registered, except that pc_o is the PC register itself.

Test Plan:
1. Reset and start:
   - Stimulus: hold rst_i=0 for 2 cycles, then release; hold start_i=0 for 3 edges.
   - Required: pc_o=0, IFID_instr_o=32'h13, valid=0 throughout.
   - Then raise start_i with instr_i=32'h00500093: after that edge pc_o=4, IFID_instr_o=32'h00500093, IFID_pc_o=0, valid=1.
2. Load-use stall:
   - Stimulus: at pc_o=8, assert stall_i=1 and PCWrite_i=0 for one edge.
   - Required: pc_o stays 8; IFID_* unchanged; stall_cnt +1.
   - Next normal edge: pc_o=12, IF/ID loads the instruction at 8.
3. Branch flush:
   - Stimulus: at pc_o=16, flush_i=1 with branch_target_i=32'h40.
   - Required: pc_o=32'h40; IFID_instr_o=32'h13, valid=0, IFID_pc_o=16; flush_cnt=1.
   - Unaligned target 32'h43: pc_o=32'h40.
4. Stall plus flush together:
   - Stimulus: stall_i=1, PCWrite_i=0, flush_i=1.
   - Required: PC and IF/ID hold; flush_cnt unchanged; stall_cnt +1.
5. Wraparound and saturation:
   - Force pc_o=32'hFFFF_FFFC with a normal edge -> pc_o=0.
   - With CNT_WIDTH=4, hold stall_i for 20 edges -> stall_cnt_o=4'hF and stays there.
6. Asynchronous reset mid-stall:
   - Stimulus: drop rst_i between edges while stall_i=1.
   - Required: outputs return to reset values immediately, without waiting for a clock edge; a fresh start_i is required to resume.
